rd_id_tracker: RTL and testbench
================================

Name: rd_id_tracker

Overview:
- Read-channel counterpart of the per-ID write tracker in the AXI monitor: tracks outstanding AR transactions per ID until the matching R beat with RLAST.
- Holds NumSlots slots; each slot has an ID, an outstanding-transaction count and a progress budget counter.
- Flags a timeout when a slot makes no R progress for a whole budget.
- Sits between the monitored master and slave ports; observes handshakes only and drives stall/timeout status to the monitor top.

Parameters:
- NumSlots, 4, number of concurrently tracked distinct read IDs
- IdWidth, 4, AXI ID width
- MaxTxnPerId, 4, maximum outstanding reads per slot; count width is $clog2(MaxTxnPerId+1)
- BudgetWidth, 10, width of the budget counter and budget_i

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- budget_i  in  BudgetWidth  idle-cycle budget, loaded at allocation and on progress
- ar_valid_i  in  1  observed AR valid
- ar_ready_i  in  1  observed AR ready
- ar_id_i  in  IdWidth  observed AR ID
- r_valid_i  in  1  observed R valid
- r_ready_i  in  1  observed R ready
- r_id_i  in  IdWidth  observed R ID
- r_last_i  in  1  observed R last
- clear_i  in  1  clears all TIMEOUT slots
- ar_stall_o  out  1  monitor must hold AR (no capacity for ar_id_i)
- timeout_o  out  1  level, high while any slot is in TIMEOUT
- timeout_id_o  out  IdWidth  ID of the lowest-index TIMEOUT slot, 0 if none
- unexpected_o  out  1  one-cycle pulse: R handshake whose ID matches no ACTIVE or TIMEOUT slot
- busy_o  out  1  any slot not FREE

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i. All slots FREE, id=0, cnt=0, budget=0. All registered outputs 0. ar_stall_o is combinational from state and inputs.
- Slot states:
  - FREE -> ACTIVE on allocation.
  - ACTIVE -> FREE when cnt reaches 0.
  - ACTIVE -> TIMEOUT when budget expires.
  - TIMEOUT -> FREE on clear_i, which also zeroes cnt.
- Matching compares against registered slot state only. A slot freed in cycle t is allocatable from t+1.
- AR handshake (ar_valid_i && ar_ready_i):
  - If an ACTIVE slot with id==ar_id_i exists: cnt+1.
  - Otherwise: allocate the lowest-index FREE slot with id=ar_id_i, cnt=1, budget=budget_i.
  - The monitor guarantees no AR handshake while ar_stall_o is high. If one occurs anyway, it is dropped with no state change.
- ar_stall_o = ar_valid_i && (matching TIMEOUT slot || (matching ACTIVE slot && cnt==MaxTxnPerId) || (no matching slot && no FREE slot)).
- R handshake (r_valid_i && r_ready_i) on an ACTIVE matching slot:
  - Any beat reloads budget=budget_i.
  - If r_last_i: cnt-1; cnt 1 -> 0 sends the slot to FREE and clears id.
- R handshake on a TIMEOUT slot is ignored, with no pulse.
- R handshake with no matching slot: unexpected_o=1 in the next cycle, no state change.
- Simultaneous AR and R-last to the same ACTIVE slot: cnt unchanged, budget reloaded, slot stays ACTIVE even if cnt was 1.
- Budget, per ACTIVE slot, each cycle without a matching R handshake:
  - If budget==0: go to TIMEOUT.
  - Otherwise: budget-1.
  - Timeout therefore registers on the (B+1)-th idle edge after load value B.
- budget_i==0 at load: timeout on the first idle edge.
- No budget activity in FREE or TIMEOUT slots.
- cnt never wraps; the stall guarantees cnt<=MaxTxnPerId. An R-last on cnt==0 cannot occur because such a slot is FREE.
- clear_i takes priority over an R handshake to a TIMEOUT slot in the same cycle.
- Reset mid-operation discards all slots immediately; no pulses are generated.

Test Plan:
- Reset, budget_i=5; AR id=3; R-last id=3 two cycles later -> busy_o high for exactly those cycles; timeout_o stays 0; slot FREE afterward.
- AR id=2, budget_i=3, no R -> timeout_o rises at the 4th edge after the AR edge; timeout_id_o=2; further AR id=2 -> ar_stall_o=1; clear_i -> timeout_o=0, ar_stall_o=0.
- 4 ARs id=1 (MaxTxnPerId=4) -> ar_stall_o=1 for a 5th AR id=1; one R-last id=1 -> stall drops the next cycle.
- ARs ids 0,1,2,3 fill all slots -> AR id=5 stalls; R-last id=0 frees slot 0; AR id=5 is accepted the next cycle into slot 0.
- R handshake id=7 with no slot -> unexpected_o one-cycle pulse; no state change.
- Slot id=4 with cnt=1: simultaneous AR id=4 and R-last id=4 -> cnt stays 1, budget reloads; a later R-last -> FREE.

Source files
------------

// File: rtl/rd_id_tracker.sv
// rd_id_tracker
// Tracks outstanding AXI read transactions per ID, from the AR handshake
// until the R beat carrying RLAST. Each slot holds an ID, an outstanding
// count and an idle budget. A slot that sees no R beat for a whole budget
// is moved to TIMEOUT and stays there until clear_i.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   budget_i              idle budget loaded at allocation and on any R beat
//   ar_valid_i/ready_i/id_i           observed AR handshake
//   r_valid_i/ready_i/id_i/last_i     observed R handshake
//   clear_i               returns every TIMEOUT slot to FREE
//   ar_stall_o            combinational: no capacity for ar_id_i right now
//   timeout_o             registered: some slot is in TIMEOUT
//   timeout_id_o          registered: ID of lowest-index TIMEOUT slot, else 0
//   unexpected_o          registered pulse: R beat matched no live slot
//   busy_o                registered: some slot is not FREE
module rd_id_tracker #(
  parameter int unsigned NumSlots    = 4,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned MaxTxnPerId = 4,
  parameter int unsigned BudgetWidth = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [BudgetWidth-1:0] budget_i,
  input  logic                   ar_valid_i,
  input  logic                   ar_ready_i,
  input  logic [IdWidth-1:0]     ar_id_i,
  input  logic                   r_valid_i,
  input  logic                   r_ready_i,
  input  logic [IdWidth-1:0]     r_id_i,
  input  logic                   r_last_i,
  input  logic                   clear_i,
  output logic                   ar_stall_o,
  output logic                   timeout_o,
  output logic [IdWidth-1:0]     timeout_id_o,
  output logic                   unexpected_o,
  output logic                   busy_o
);

  localparam int unsigned CntWidth = $clog2(MaxTxnPerId + 1);
  localparam int unsigned IdxWidth = (NumSlots > 1) ? $clog2(NumSlots) : 1;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_ACTIVE  = 2'd1,
    SLOT_TIMEOUT = 2'd2
  } slot_state_e;

  slot_state_e            state_q  [NumSlots];
  slot_state_e            state_d  [NumSlots];
  logic [IdWidth-1:0]     id_q     [NumSlots];
  logic [IdWidth-1:0]     id_d     [NumSlots];
  logic [CntWidth-1:0]    cnt_q    [NumSlots];
  logic [CntWidth-1:0]    cnt_d    [NumSlots];
  logic [BudgetWidth-1:0] budget_q [NumSlots];
  logic [BudgetWidth-1:0] budget_d [NumSlots];

  logic                ar_hs_s;
  logic                r_hs_s;
  logic                ar_act_hit_s;
  logic [IdxWidth-1:0] ar_act_idx_s;
  logic                ar_to_hit_s;
  logic                free_hit_s;
  logic [IdxWidth-1:0] free_idx_s;
  logic                r_hit_s;
  logic                ar_stall_s;
  logic                ar_acc_s;

  logic                timeout_d;
  logic [IdWidth-1:0]  timeout_id_d;
  logic                unexpected_d;
  logic                busy_d;

  // Lookup of the registered slot table against the AR and R IDs.
  // Loops run from the top index down so the lowest index wins.
  always_comb begin
    ar_hs_s      = ar_valid_i && ar_ready_i;
    r_hs_s       = r_valid_i && r_ready_i;
    ar_act_hit_s = 1'b0;
    ar_act_idx_s = '0;
    ar_to_hit_s  = 1'b0;
    free_hit_s   = 1'b0;
    free_idx_s   = '0;
    r_hit_s      = 1'b0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (state_q[i] == SLOT_FREE) begin
        free_hit_s = 1'b1;
        free_idx_s = IdxWidth'(i);
      end else begin
        if (id_q[i] == ar_id_i) begin
          if (state_q[i] == SLOT_ACTIVE) begin
            ar_act_hit_s = 1'b1;
            ar_act_idx_s = IdxWidth'(i);
          end else begin
            ar_to_hit_s = 1'b1;
          end
        end else begin
          ar_to_hit_s = ar_to_hit_s;
        end
        if (id_q[i] == r_id_i) begin
          r_hit_s = 1'b1;
        end else begin
          r_hit_s = r_hit_s;
        end
      end
    end
    ar_stall_s = ar_valid_i &&
                 (ar_to_hit_s ||
                  (ar_act_hit_s && (cnt_q[ar_act_idx_s] == CntWidth'(MaxTxnPerId))) ||
                  (!ar_act_hit_s && !ar_to_hit_s && !free_hit_s));
    // A handshake that slips through while stalled is dropped.
    ar_acc_s   = ar_hs_s && !ar_stall_s;
  end

  assign ar_stall_o = ar_stall_s;

  // Per-slot next state: allocation, count/budget updates, timeout and clear.
  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      state_d[i]  = state_q[i];
      id_d[i]     = id_q[i];
      cnt_d[i]    = cnt_q[i];
      budget_d[i] = budget_q[i];
      case (state_q[i])
        SLOT_FREE: begin
          if (ar_acc_s && !ar_act_hit_s && (free_idx_s == IdxWidth'(i))) begin
            state_d[i]  = SLOT_ACTIVE;
            id_d[i]     = ar_id_i;
            cnt_d[i]    = CntWidth'(1);
            budget_d[i] = budget_i;
          end else begin
            state_d[i] = SLOT_FREE;
          end
        end
        SLOT_ACTIVE: begin
          if (r_hs_s && (id_q[i] == r_id_i)) begin
            budget_d[i] = budget_i;
            // AR and R-last landing together cancel out, so the slot stays.
            if (ar_acc_s && ar_act_hit_s && (ar_act_idx_s == IdxWidth'(i))) begin
              if (r_last_i) begin
                cnt_d[i] = cnt_q[i];
              end else begin
                cnt_d[i] = cnt_q[i] + CntWidth'(1);
              end
            end else if (r_last_i) begin
              if (cnt_q[i] == CntWidth'(1)) begin
                state_d[i]  = SLOT_FREE;
                id_d[i]     = '0;
                cnt_d[i]    = '0;
                budget_d[i] = '0;
              end else begin
                cnt_d[i] = cnt_q[i] - CntWidth'(1);
              end
            end else begin
              cnt_d[i] = cnt_q[i];
            end
          end else begin
            if (ar_acc_s && ar_act_hit_s && (ar_act_idx_s == IdxWidth'(i))) begin
              cnt_d[i] = cnt_q[i] + CntWidth'(1);
            end else begin
              cnt_d[i] = cnt_q[i];
            end
            if (budget_q[i] == '0) begin
              state_d[i] = SLOT_TIMEOUT;
            end else begin
              budget_d[i] = budget_q[i] - BudgetWidth'(1);
            end
          end
        end
        SLOT_TIMEOUT: begin
          // clear_i wins over any R beat to this slot; R beats are otherwise ignored.
          if (clear_i) begin
            state_d[i]  = SLOT_FREE;
            id_d[i]     = '0;
            cnt_d[i]    = '0;
            budget_d[i] = '0;
          end else begin
            state_d[i] = SLOT_TIMEOUT;
          end
        end
        default: begin
          state_d[i]  = SLOT_FREE;
          id_d[i]     = '0;
          cnt_d[i]    = '0;
          budget_d[i] = '0;
        end
      endcase
    end
  end

  // Status outputs derived from next state so they line up with the slot table.
  always_comb begin
    timeout_d    = 1'b0;
    timeout_id_d = '0;
    busy_d       = 1'b0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (state_d[i] == SLOT_TIMEOUT) begin
        timeout_d    = 1'b1;
        timeout_id_d = id_d[i];
      end else begin
        timeout_d = timeout_d;
      end
      if (state_d[i] != SLOT_FREE) begin
        busy_d = 1'b1;
      end else begin
        busy_d = busy_d;
      end
    end
    unexpected_d = r_hs_s && !r_hit_s;
  end

  // Slot table and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumSlots; i++) begin
        state_q[i]  <= SLOT_FREE;
        id_q[i]     <= '0;
        cnt_q[i]    <= '0;
        budget_q[i] <= '0;
      end
      timeout_o    <= 1'b0;
      timeout_id_o <= '0;
      unexpected_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        state_q[i]  <= state_d[i];
        id_q[i]     <= id_d[i];
        cnt_q[i]    <= cnt_d[i];
        budget_q[i] <= budget_d[i];
      end
      timeout_o    <= timeout_d;
      timeout_id_o <= timeout_id_d;
      unexpected_o <= unexpected_d;
      busy_o       <= busy_d;
    end
  end

endmodule

// File: tb/tb_rd_id_tracker.sv
module tb_rd_id_tracker;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [9:0] budget_i;
  logic       ar_valid_i, ar_ready_i;
  logic [3:0] ar_id_i;
  logic       r_valid_i, r_ready_i, r_last_i;
  logic [3:0] r_id_i;
  logic       clear_i;
  logic       ar_stall_o, timeout_o, unexpected_o, busy_o;
  logic [3:0] timeout_id_o;

  int n_cmp = 0;
  int n_err = 0;

  rd_id_tracker #(
    .NumSlots(4), .IdWidth(4), .MaxTxnPerId(4), .BudgetWidth(10)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .budget_i(budget_i),
    .ar_valid_i(ar_valid_i), .ar_ready_i(ar_ready_i), .ar_id_i(ar_id_i),
    .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_id_i(r_id_i),
    .r_last_i(r_last_i), .clear_i(clear_i),
    .ar_stall_o(ar_stall_o), .timeout_o(timeout_o), .timeout_id_o(timeout_id_o),
    .unexpected_o(unexpected_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    ar_valid_i = 1'b0; ar_ready_i = 1'b0; ar_id_i = 4'd0;
    r_valid_i  = 1'b0; r_ready_i  = 1'b0; r_id_i  = 4'd0; r_last_i = 1'b0;
    clear_i    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    budget_i = 10'd0;
    rst_ni   = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    budget_i = 10'd5;
    rst_ni   = 1'b0;
    #3;
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    n_cmp++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b exp 0", timeout_o); end
    n_cmp++; if (timeout_id_o !== 4'd0) begin n_err++; $display("FAIL reset_tid got %0d exp 0", timeout_id_o); end
    n_cmp++; if (unexpected_o !== 1'b0) begin n_err++; $display("FAIL reset_unexp got %b exp 0", unexpected_o); end
    n_cmp++; if (ar_stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", ar_stall_o); end
    tick();
    rst_ni = 1'b1;
  endtask

  // AR id 3, R-last id 3 two edges later.
  task automatic test_basic();
    do_reset();
    budget_i = 10'd5;
    ar_valid_i = 1'b1; ar_ready_i = 1'b1; ar_id_i = 4'd3;
    #1;
    n_cmp++; if (ar_stall_o !== 1'b0) begin n_err++; $display("FAIL basic_stall got %b exp 0", ar_stall_o); end
    tick();
    idle_inputs();
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL basic_busy1 got %b exp 1", busy_o); end
    tick();
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL basic_busy2 got %b exp 1", busy_o); end
    r_valid_i = 1'b1; r_ready_i = 1'b1; r_id_i = 4'd3; r_last_i = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL basic_free got %b exp 0", busy_o); end
    n_cmp++; if (unexpected_o !== 1'b0) begin n_err++; $display("FAIL basic_unexp got %b exp 0", unexpected_o); end
    tick();
    n_cmp++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL basic_timeout got %b exp 0", timeout_o); end
  endtask

  // AR id 2 with budget 3, no R: timeout on the 4th edge after the AR edge.
  task automatic test_timeout();
    do_reset();
    budget_i = 10'd3;
    ar_valid_i = 1'b1; ar_ready_i = 1'b1; ar_id_i = 4'd2;
    tick();
    idle_inputs();
    tick(); tick(); tick();
    n_cmp++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL to_early got %b exp 0", timeout_o); end
    tick();
    n_cmp++; if (timeout_o !== 1'b1) begin n_err++; $display("FAIL to_rise got %b exp 1", timeout_o); end
    n_cmp++; if (timeout_id_o !== 4'd2) begin n_err++; $display("FAIL to_id got %0d exp 2", timeout_id_o); end
    ar_valid_i = 1'b1; ar_id_i = 4'd2;
    #1;
    n_cmp++; if (ar_stall_o !== 1'b1) begin n_err++; $display("FAIL to_stall got %b exp 1", ar_stall_o); end
    ar_id_i = 4'd6;
    #1;
    n_cmp++; if (ar_stall_o !== 1'b0) begin n_err++; $display("FAIL to_other_id got %b exp 0", ar_stall_o); end
    ar_valid_i = 1'b0;
    // R beat to a timed-out slot: ignored, no pulse.
    r_valid_i = 1'b1; r_ready_i = 1'b1; r_id_i = 4'd2; r_last_i = 1'b1;
    tick();
    n_cmp++; if (unexpected_o !== 1'b0) begin n_err++; $display("FAIL to_r_unexp got %b exp 0", unexpected_o); end
    n_cmp++; if (timeout_o !== 1'b1) begin n_err++; $display("FAIL to_r_hold got %b exp 1", timeout_o); end
    // clear_i together with another R beat to the slot.
    clear_i = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL to_clear got %b exp 0", timeout_o); end
    n_cmp++; if (timeout_id_o !== 4'd0) begin n_err++; $display("FAIL to_clear_id got %0d exp 0", timeout_id_o); end
    n_cmp++; if (unexpected_o !== 1'b0) begin n_err++; $display("FAIL to_clear_unexp got %b exp 0", unexpected_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL to_clear_busy got %b exp 0", busy_o); end
    ar_valid_i = 1'b1; ar_id_i = 4'd2;
    #1;
    n_cmp++; if (ar_stall_o !== 1'b0) begin n_err++; $display("FAIL to_clear_stall got %b exp 0", ar_stall_o); end
    idle_inputs();
  endtask

  // Four ARs id 1 fill the per-ID count; one R-last releases the stall.
  task automatic test_max_per_id();
    do_reset();
    budget_i = 10'd100;
    ar_valid_i = 1'b1; ar_ready_i = 1'b1; ar_id_i = 4'd1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (ar_stall_o !== 1'b0) begin n_err++; $display("FAIL max_fill%0d got %b exp 0", k, ar_stall_o); end
      tick();
    end
    ar_ready_i = 1'b0;
    #1;
    n_cmp++; if (ar_stall_o !== 1'b1) begin n_err++; $display("FAIL max_stall got %b exp 1", ar_stall_o); end
    r_valid_i = 1'b1; r_ready_i = 1'b1; r_id_i = 4'd1; r_last_i = 1'b1;
    #1;
    n_cmp++; if (ar_stall_o !== 1'b1) begin n_err++; $display("FAIL max_stall_same got %b exp 1", ar_stall_o); end
    tick();
    r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
    #1;
    n_cmp++; if (ar_stall_o !== 1'b0) begin n_err++; $display("FAIL max_release got %b exp 0", ar_stall_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL max_busy got %b exp 1", busy_o); end
    idle_inputs();
  endtask

  // All slots full; freeing slot 0 lets AR id 5 in the next cycle.
  task automatic test_full();
    do_reset();
    budget_i = 10'd100;
    ar_valid_i = 1'b1; ar_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ar_id_i = 4'(k);
      tick();
    end
    ar_id_i = 4'd5; ar_ready_i = 1'b0;
    #1;
    n_cmp++; if (ar_stall_o !== 1'b1) begin n_err++; $display("FAIL full_stall got %b exp 1", ar_stall_o); end
    r_valid_i = 1'b1; r_ready_i = 1'b1; r_id_i = 4'd0; r_last_i = 1'b1;
    tick();
    r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
    #1;
    n_cmp++; if (ar_stall_o !== 1'b0) begin n_err++; $display("FAIL full_freed got %b exp 0", ar_stall_o); end
    // Allocate with a zero budget: timeout on the first idle edge.
    ar_ready_i = 1'b1; budget_i = 10'd0;
    tick();
    idle_inputs();
    n_cmp++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL full_alloc_to got %b exp 0", timeout_o); end
    tick();
    n_cmp++; if (timeout_o !== 1'b1) begin n_err++; $display("FAIL full_zero_budget got %b exp 1", timeout_o); end
    n_cmp++; if (timeout_id_o !== 4'd5) begin n_err++; $display("FAIL full_zero_id got %0d exp 5", timeout_id_o); end
    // Let slots 1..3 expire too; slot 0 (id 5) must stay lowest.
    for (int k = 0; k < 110; k++) tick();
    n_cmp++; if (timeout_id_o !== 4'd5) begin n_err++; $display("FAIL full_slot0 got %0d exp 5", timeout_id_o); end
    clear_i = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL full_clear got %b exp 0", busy_o); end
  endtask

  // R beat with no slot gives a single-cycle pulse.
  task automatic test_unexpected();
    do_reset();
    r_valid_i = 1'b1; r_ready_i = 1'b1; r_id_i = 4'd7; r_last_i = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (unexpected_o !== 1'b1) begin n_err++; $display("FAIL unexp_pulse got %b exp 1", unexpected_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL unexp_busy got %b exp 0", busy_o); end
    tick();
    n_cmp++; if (unexpected_o !== 1'b0) begin n_err++; $display("FAIL unexp_fall got %b exp 0", unexpected_o); end
  endtask

  // Simultaneous AR and R-last on id 4 with cnt 1.
  task automatic test_back_to_back();
    do_reset();
    budget_i = 10'd3;
    ar_valid_i = 1'b1; ar_ready_i = 1'b1; ar_id_i = 4'd4;
    tick();
    idle_inputs();
    tick(); tick();
    ar_valid_i = 1'b1; ar_ready_i = 1'b1; ar_id_i = 4'd4;
    r_valid_i = 1'b1; r_ready_i = 1'b1; r_id_i = 4'd4; r_last_i = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL b2b_stay got %b exp 1", busy_o); end
    tick(); tick(); tick();
    n_cmp++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL b2b_reload got %b exp 0", timeout_o); end
    r_valid_i = 1'b1; r_ready_i = 1'b1; r_id_i = 4'd4; r_last_i = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL b2b_free got %b exp 0", busy_o); end
    n_cmp++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL b2b_timeout got %b exp 0", timeout_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_max_per_id();
    test_full();
    test_unexpected();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
